// File: rtl/secuenciador_pc_if.sv
// Instruction-memory fetch channel used by secuenciador_pc.
//
// Signals:
//   imem_req    sequencer -> memory  fetch request, held high until acknowledged
//   imem_addr   sequencer -> memory  word address being fetched (the current pc)
//   imem_ack    memory -> sequencer  imem_rdata holds the requested word
//   imem_rdata  memory -> sequencer  instruction word
//
// Modports:
//   master  sequencer side (drives req/addr)
//   slave   memory side (drives ack/rdata)
interface secuenciador_pc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/secuenciador_pc.sv
// Multicycle next-PC sequencer for the processor front end.
//
// Fetches one instruction word over the imem request/acknowledge channel, issues it to decode
// with a one-cycle instr_valid pulse, and then updates the architectural PC to PC+4, a
// conditional-branch target, a J/JAL target or a JR register target.
//
// Parameters:
//   RESET_PC     pc value loaded on reset
//   TRAP_VECTOR  misaligned-JR trap target (only meaningful when PC_TRAP_EN is defined)
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        leave IDLE and begin fetching (sampled only in IDLE)
//   halt         return to IDLE after the current UPDATE (sampled only in UPDATE)
//   imem         fetch channel, master side (imem_req / imem_addr / imem_ack / imem_rdata)
//   cond_valid   branch condition available (sampled only in WAIT_COND)
//   cond_taken   branch taken, qualified by cond_valid
//   rs_data      JR register operand (sampled in ISSUE)
//   pc           architectural PC
//   instr        latched instruction word
//   instr_valid  one-cycle issue pulse
//   trap         one-cycle pulse in the UPDATE of a misaligned JR (PC_TRAP_EN only)
//   epc          address of the last trapping JR (PC_TRAP_EN only)
//
// Build option:
//   PC_TRAP_EN   when defined, a misaligned JR redirects to TRAP_VECTOR, records epc and pulses
//                trap; when undefined, JR targets are force-aligned and trap/epc are tied to 0.
//
// Cycle sequence for a non-branch with immediate ack: FETCH, ISSUE, UPDATE, FETCH(new pc).
// Each branch adds WAIT_COND cycles until cond_valid arrives.
module secuenciador_pc #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     halt,
  secuenciador_pc_if.master        imem,
  input  logic                     cond_valid,
  input  logic                     cond_taken,
  input  logic [31:0]              rs_data,
  output logic [31:0]              pc,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic                     trap,
  output logic [31:0]              epc
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] FunctJr   = 6'h08;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWaitCond,
    StUpdate
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        imem_req_q;
  logic        taken_q;
  logic [29:0] jr_q;        // word-aligned part of the JR operand

  // ---------------------------------------------------------------------------------------------
  // Decode of the latched instruction
  // ---------------------------------------------------------------------------------------------
  logic [5:0]  op;
  logic        is_branch;
  logic        is_jump;
  logic        is_jr;

  assign op        = instr_q[31:26];
  assign is_branch = (op == OpBeq) || (op == OpBne);
  assign is_jump   = (op == OpJ) || (op == OpJal);
  assign is_jr     = (op == OpSpecial) && (instr_q[5:0] == FunctJr);

  // ---------------------------------------------------------------------------------------------
  // Candidate targets
  // ---------------------------------------------------------------------------------------------
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic [31:0] next_pc;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  // Low operand bits are dropped, so a misaligned JR lands on the enclosing word.
  assign jr_target = {jr_q, 2'b00};

`ifdef PC_TRAP_EN
  logic        trap_q;
  logic [31:0] epc_q;
  logic        jr_misaligned;

  // Evaluated in ISSUE, where rs_data is sampled.
  assign jr_misaligned = is_jr && (rs_data[1:0] != 2'b00);
`endif

  always_comb begin
    next_pc = pc_plus4;
    if (is_branch) begin
      next_pc = taken_q ? br_target : pc_plus4;
    end else if (is_jump) begin
      next_pc = j_target;
    end else if (is_jr) begin
      next_pc = jr_target;
    end
`ifdef PC_TRAP_EN
    // trap_q is high only during the UPDATE of a misaligned JR.
    if (trap_q) begin
      next_pc = TRAP_VECTOR;
    end
`endif
  end

  // ---------------------------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      taken_q       <= 1'b0;
      jr_q          <= 30'h0;
`ifdef PC_TRAP_EN
      trap_q        <= 1'b0;
      epc_q         <= 32'h0;
`endif
    end else begin
      // Single-cycle pulses default low.
      instr_valid_q <= 1'b0;
`ifdef PC_TRAP_EN
      trap_q        <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end
        end

        StFetch: begin
          if (imem.imem_ack) begin
            instr_q       <= imem.imem_rdata;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= StIssue;
          end
        end

        StIssue: begin
          jr_q <= rs_data[31:2];
          if (is_branch) begin
            state_q <= StWaitCond;
          end else begin
            state_q <= StUpdate;
`ifdef PC_TRAP_EN
            trap_q  <= jr_misaligned;
`endif
          end
        end

        StWaitCond: begin
          if (cond_valid) begin
            taken_q <= cond_taken;
            state_q <= StUpdate;
          end
        end

        StUpdate: begin
          pc_q <= next_pc;
`ifdef PC_TRAP_EN
          if (trap_q) begin
            epc_q <= pc_q;
          end
`endif
          if (halt) begin
            state_q <= StIdle;
          end else begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end
        end

        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;

`ifdef PC_TRAP_EN
  assign trap = trap_q;
  assign epc  = epc_q;
`else
  assign trap = 1'b0;
  assign epc  = 32'h0;

  // Only consumed by the trap logic.
  logic unused_trap;
  assign unused_trap = ^{TRAP_VECTOR, rs_data[1:0]};
`endif

endmodule

// File: tb/tb_secuenciador_pc.sv
// Self-checking bench for secuenciador_pc: directed scenarios followed by randomized
// instruction streams. A driver plays instruction memory, the condition unit and the
// register file; expected fetches, issues and traps are queued and a monitor checks them.
module tb_secuenciador_pc;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0180;
  localparam logic [31:0] ADD_W       = 32'h0043_1020;
  localparam logic [31:0] JR_W        = 32'h03e0_0008;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        halt;
  logic        cond_valid;
  logic        cond_taken;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        trap;
  logic [31:0] epc;

  secuenciador_pc_if imem_if ();

  secuenciador_pc #(
    .RESET_PC    (RESET_PC),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .halt        (halt),
    .imem        (imem_if),
    .cond_valid  (cond_valid),
    .cond_taken  (cond_taken),
    .rs_data     (rs_data),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .trap        (trap),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t fetch_q[$];
  exp_t iss_q[$];
  exp_t trap_q[$];

  logic [31:0] model_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: next PC from the architectural rules, plain arithmetic on addresses.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic [31:0] rs, input bit tk,
                                           output bit trp);
    int          off;
    logic [31:0] seq;
    seq = p + 32'd4;
    trp = 1'b0;
    off = $signed(w[15:0]);
    case (w[31:26])
      6'h04, 6'h05: return tk ? seq + 32'(off * 4) : seq;
      6'h02, 6'h03: return {seq[31:28], 28'h0} | (32'(w[25:0]) << 2);
      6'h00: begin
        if (w[5:0] == 6'h08) begin
          if (rs % 4 != 0) begin
`ifdef PC_TRAP_EN
            trp = 1'b1;
            return TRAP_VECTOR;
`else
            return rs - (rs % 4);
`endif
          end
          return rs;
        end
      end
      default: ;
    endcase
    return seq;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------------------------
  logic        req_prev = 1'b0;
  logic [31:0] cur_fetch = 32'h0;
  bit          epc_pending = 1'b0;
  logic [31:0] epc_exp = 32'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      req_prev = 1'b0;
    end else begin
      if (imem_if.imem_req && !req_prev) begin
        if (fetch_q.size() == 0) begin
          chk("fetch_unexpected", 32'(imem_if.imem_addr), 32'hxxxx_xxxx);
        end else begin
          e = fetch_q.pop_front();
          cur_fetch = e.val;
          chk("fetch_addr", imem_if.imem_addr, e.val);
          chk("fetch_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (imem_if.imem_req) begin
        chk("fetch_hold", imem_if.imem_addr, cur_fetch);
      end
      req_prev = imem_if.imem_req;

      if (instr_valid) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", instr, 32'hxxxx_xxxx);
        end else begin
          e = iss_q.pop_front();
          chk("issue_instr", instr, e.val);
          chk("issue_cycle", 32'(cyc), 32'(e.cyc));
        end
`ifndef PC_TRAP_EN
        chk("epc_tied", epc, 32'h0);
`endif
      end

      if (epc_pending) begin
        chk("epc", epc, epc_exp);
        epc_pending = 1'b0;
      end
      if (trap) begin
        if (trap_q.size() == 0) begin
          chk("trap_unexpected", 32'(trap), 32'h0);
        end else begin
          e = trap_q.pop_front();
          chk("trap_cycle", 32'(cyc), 32'(e.cyc));
          epc_exp     = e.val;
          epc_pending = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------------------------
  task automatic wait_req();
    int t = 0;
    while (!imem_if.imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!imem_if.imem_req) chk("wait_req_timeout", 32'(imem_if.imem_req), 32'h1);
  endtask

  task automatic kick();
    start = 1'b1;
    fetch_q.push_back('{model_pc, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_instr(input logic [31:0] w, input logic [31:0] rs, input bit tk,
                          input int ack_dly, input int cond_dly, input bit hlt);
    int          a;
    int          u;
    bit          trp;
    bit          is_br;
    logic [31:0] nxt;
    wait_req();
    for (int i = 0; i < ack_dly; i++) begin
      halt       = 1'($urandom_range(0, 1));
      cond_valid = 1'($urandom_range(0, 1));
      cond_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = w;
    rs_data            = rs;
    halt               = hlt;
    start              = 1'($urandom_range(0, 1));
    cond_valid         = 1'($urandom_range(0, 1));
    cond_taken         = 1'($urandom_range(0, 1));
    a     = cyc;
    is_br = (w[31:26] == 6'h04) || (w[31:26] == 6'h05);
    u     = is_br ? a + 3 + cond_dly : a + 2;
    nxt   = ref_next(model_pc, w, rs, tk, trp);
    iss_q.push_back('{w, a + 1});
    if (trp) trap_q.push_back('{model_pc, u});
    if (!hlt) fetch_q.push_back('{nxt, u + 1});
    model_pc = nxt;

    @(negedge clk);                     // ISSUE
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = $urandom;
    start              = 1'b0;
    @(negedge clk);                     // rs_data has been sampled
    rs_data    = $urandom;
    cond_valid = 1'b0;
    if (is_br) begin
      for (int i = 0; i < cond_dly; i++) @(negedge clk);
      cond_valid = 1'b1;
      cond_taken = tk;
      @(negedge clk);
      cond_valid = 1'b0;
      cond_taken = 1'($urandom_range(0, 1));
    end
    while (cyc <= u) @(negedge clk);
    halt = 1'b0;
    if (hlt) begin
      for (int i = 0; i < 3; i++) begin
        chk("halted_req", 32'(imem_if.imem_req), 32'h0);
        @(negedge clk);
      end
    end
  endtask

  task automatic reset_in_fetch();
    wait_req();
    repeat (2) @(negedge clk);          // third FETCH cycle, no ack yet
    #2 reset_n = 1'b0;
    #1;
    chk("rst_req_async", 32'(imem_if.imem_req), 32'h0);
    chk("rst_pc_async", pc, RESET_PC);
    chk("rst_ivalid_async", 32'(instr_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_idle", 32'(imem_if.imem_req), 32'h0);
      @(negedge clk);
    end
    model_pc = RESET_PC;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {6'h00, r[25:6], 6'h20};
      1: return {5'b00010, r[26:0]};                       // BEQ / BNE
      2: return {5'b00001, r[26:0]};                       // J / JAL
      3: return {6'h00, r[25:6], 6'h08};
      4: return {6'($urandom_range(6, 63)), r[25:0]};
      default: return {6'h00, r[25:6], 6'($urandom_range(9, 63))};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n            = 1'b0;
    start              = 1'b0;
    halt               = 1'b0;
    cond_valid         = 1'b0;
    cond_taken         = 1'b0;
    rs_data            = 32'h0;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ivalid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem_if.imem_req), 32'h0);
    chk("rst_trap", 32'(trap), 32'h0);
    chk("rst_epc", epc, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("idle_req", 32'(imem_if.imem_req), 32'h0);
      @(negedge clk);
    end
    model_pc = RESET_PC;
    kick();

    // Back-to-back ADDs, immediate ack: fetches at 0x0, 0x4, 0x8, three cycles apart.
    for (int i = 0; i < 3; i++) do_instr(ADD_W, 32'h0, 1'b0, 0, 0, 1'b0);
    do_instr({6'h02, 26'h40}, 32'h0, 1'b0, 0, 0, 1'b0);             // to 0x100
    do_instr({6'h04, 10'h0, 16'hffff}, 32'h0, 1'b1, 0, 2, 1'b0);   // taken: back to 0x100
    do_instr({6'h04, 10'h0, 16'hffff}, 32'h0, 1'b0, 0, 2, 1'b0);   // not taken: 0x104
    do_instr(JR_W, 32'h1000_0000, 1'b0, 1, 0, 1'b0);
    do_instr({6'h02, 26'h10}, 32'h0, 1'b0, 0, 0, 1'b0);             // 0x1000_0040
    do_instr({6'h03, 26'h10}, 32'h0, 1'b0, 0, 0, 1'b0);             // self-loop via JAL
    do_instr(JR_W, 32'h0000_2002, 1'b0, 0, 0, 1'b0);                // misaligned JR
    do_instr(JR_W, 32'hffff_fffc, 1'b0, 0, 0, 1'b0);
    do_instr(ADD_W, 32'h0, 1'b0, 0, 0, 1'b1);                        // wraps to 0, halts
    kick();
    reset_in_fetch();
    kick();

    for (int n = 0; n < 200; n++) begin
      logic [31:0] rs;
      bit          hlt;
      rs  = $urandom;
      if ($urandom_range(0, 1) == 0) rs[1:0] = 2'b00;
      hlt = ($urandom_range(0, 9) == 0);
      do_instr(rand_word(), rs, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom_range(0, 3), hlt);
      if (hlt) kick();
    end
    do_instr(ADD_W, 32'h0, 1'b0, 0, 0, 1'b1);

    repeat (3) @(negedge clk);
    chk("fetch_q_drained", 32'(fetch_q.size()), 32'h0);
    chk("iss_q_drained", 32'(iss_q.size()), 32'h0);
    chk("trap_q_drained", 32'(trap_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
